// File: rtl/ex_result_buffer_if.sv
// ex_result_buffer_if: execute-to-memory result handshake plus decode forwarding lookup.
interface ex_result_buffer_if #(
    parameter int size = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [size-1:0] in_result;
    logic [4:0]      in_rd;
    logic            in_we;
    logic            out_valid;
    logic            out_ready;
    logic [size-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_we;
    logic [4:0]      fwd_rs1;
    logic [4:0]      fwd_rs2;
    logic            fwd_hit1;
    logic            fwd_hit2;
    logic [size-1:0] fwd_data1;
    logic [size-1:0] fwd_data2;
    logic [1:0]      count;

    modport master (
        output flush, in_valid, in_result, in_rd, in_we, out_ready, fwd_rs1, fwd_rs2,
        input  in_ready, out_valid, out_result, out_rd, out_we, fwd_hit1, fwd_hit2,
               fwd_data1, fwd_data2, count
    );

    modport slave (
        input  flush, in_valid, in_result, in_rd, in_we, out_ready, fwd_rs1, fwd_rs2,
        output in_ready, out_valid, out_result, out_rd, out_we, fwd_hit1, fwd_hit2,
               fwd_data1, fwd_data2, count
    );
endinterface

// File: rtl/ex_result_buffer.sv
// ex_result_buffer: two-entry result FIFO between execute and memory with forwarding lookup.
module ex_result_buffer #(
    parameter int size  = 32,
    parameter int depth = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    ex_result_buffer_if.slave  bus
);
    logic [size-1:0] r_result [0:1];
    logic [4:0]      r_rd     [0:1];
    logic [1:0]      r_we;
    logic            r_head;
    logic            r_tail;
    logic [1:0]      r_count;

    logic w_push, w_pop, w_yi, w_occ_o, w_occ_y;
    logic w_o1, w_y1, w_o2, w_y2;

    assign bus.in_ready  = r_count != 2'(depth);
    assign bus.out_valid = r_count != 2'd0;
    assign bus.count     = r_count;
    assign w_push = bus.in_valid && bus.in_ready && !bus.flush;
    assign w_pop  = bus.out_valid && bus.out_ready && !bus.flush;

    always_comb begin
        bus.out_result = bus.out_valid ? r_result[r_head] : '0;
        bus.out_rd     = bus.out_valid ? r_rd[r_head] : '0;
        bus.out_we     = bus.out_valid ? r_we[r_head] : 1'b0;
    end

    // The younger entry sits just behind the tail, i.e. the slot after the head when full.
    assign w_yi    = ~r_head;
    assign w_occ_o = r_count != 2'd0;
    assign w_occ_y = r_count == 2'd2;
    assign w_o1 = w_occ_o && r_we[r_head] && r_rd[r_head] == bus.fwd_rs1 && |bus.fwd_rs1;
    assign w_y1 = w_occ_y && r_we[w_yi]   && r_rd[w_yi]   == bus.fwd_rs1 && |bus.fwd_rs1;
    assign w_o2 = w_occ_o && r_we[r_head] && r_rd[r_head] == bus.fwd_rs2 && |bus.fwd_rs2;
    assign w_y2 = w_occ_y && r_we[w_yi]   && r_rd[w_yi]   == bus.fwd_rs2 && |bus.fwd_rs2;

    always_comb begin
        bus.fwd_hit1  = w_o1 || w_y1;
        bus.fwd_hit2  = w_o2 || w_y2;
        bus.fwd_data1 = w_y1 ? r_result[w_yi] : w_o1 ? r_result[r_head] : '0;
        bus.fwd_data2 = w_y2 ? r_result[w_yi] : w_o2 ? r_result[r_head] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_result[i] <= '0;
                r_rd[i]     <= '0;
            end
            r_we    <= '0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else if (bus.flush) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_result[r_tail] <= bus.in_result;
                r_rd[r_tail]     <= bus.in_rd;
                r_we[r_tail]     <= bus.in_we;
                r_tail           <= ~r_tail;
            end
            if (w_pop)
                r_head <= ~r_head;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: tb/tb_ex_result_buffer.sv
// tb_ex_result_buffer: directed checks of ordering, backpressure, forwarding, flush and reset.
module tb_ex_result_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    ex_result_buffer_if #(.size(32)) bus ();
    ex_result_buffer #(.size(32), .depth(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd, input logic we);
        bus.in_valid  = v;
        bus.in_result = res;
        bus.in_rd     = rd;
        bus.in_we     = we;
    endtask

    initial begin
        bus.flush = 0; bus.out_ready = 0; bus.fwd_rs1 = 0; bus.fwd_rs2 = 0;
        drive(0, 0, 0, 0);
        tick(); tick();
        rst_n = 1;
        #1;
        check("rst_count", 64'(bus.count), 0);
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_in_ready", 64'(bus.in_ready), 1);
        check("rst_out_result", 64'(bus.out_result), 0);

        drive(1, 32'hDEADBEEF, 5, 1);
        #1;
        check("no_bypass", 64'(bus.out_valid), 0);
        tick();
        drive(0, 0, 0, 0);
        check("p1_valid", 64'(bus.out_valid), 1);
        check("p1_result", 64'(bus.out_result), 64'hDEADBEEF);
        check("p1_rd", 64'(bus.out_rd), 5);
        check("p1_we", 64'(bus.out_we), 1);
        check("p1_count", 64'(bus.count), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("p1_hold", 64'(bus.out_result), 64'hDEADBEEF);
        end
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        check("p1_empty", 64'(bus.count), 0);
        check("p1_out_zero", 64'(bus.out_result), 0);

        drive(1, 32'h11, 1, 1);
        tick();
        drive(1, 32'h22, 2, 1);
        tick();
        check("full_count", 64'(bus.count), 2);
        check("full_in_ready", 64'(bus.in_ready), 0);
        drive(1, 32'h99, 9, 1);
        tick();
        drive(0, 0, 0, 0);
        check("third_ignored", 64'(bus.count), 2);
        check("head_11", 64'(bus.out_result), 32'h11);
        bus.out_ready = 1;
        #1;
        check("ready_not_comb", 64'(bus.in_ready), 0);
        tick();
        check("head_22", 64'(bus.out_result), 32'h22);
        check("ready_after_pop", 64'(bus.in_ready), 1);
        check("count_after_pop", 64'(bus.count), 1);
        tick();
        bus.out_ready = 0;
        check("drained", 64'(bus.out_valid), 0);

        drive(1, 32'h44, 4, 1);
        tick();
        drive(1, 32'h33, 6, 1);
        bus.out_ready = 1;
        tick();
        drive(0, 0, 0, 0);
        bus.out_ready = 0;
        check("pp_count", 64'(bus.count), 1);
        check("pp_result", 64'(bus.out_result), 32'h33);
        check("pp_rd", 64'(bus.out_rd), 6);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;

        drive(1, 32'hA, 7, 1);
        tick();
        drive(1, 32'hB, 7, 1);
        tick();
        drive(0, 0, 0, 0);
        bus.fwd_rs1 = 7; bus.fwd_rs2 = 0;
        #1;
        check("fwd_hit1", 64'(bus.fwd_hit1), 1);
        check("fwd_young", 64'(bus.fwd_data1), 32'hB);
        check("fwd_hit2_r0", 64'(bus.fwd_hit2), 0);
        check("fwd_data2_r0", 64'(bus.fwd_data2), 0);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        drive(1, 32'hC, 3, 0);
        tick();
        drive(0, 0, 0, 0);
        bus.fwd_rs1 = 3; bus.fwd_rs2 = 7;
        #1;
        check("fwd_we0_hit", 64'(bus.fwd_hit1), 0);
        check("fwd_we0_data", 64'(bus.fwd_data1), 0);
        check("fwd_old_hit", 64'(bus.fwd_hit2), 1);
        check("fwd_old_data", 64'(bus.fwd_data2), 32'hB);

        bus.flush = 1;
        bus.out_ready = 1;
        drive(1, 32'h55, 8, 1);
        tick();
        bus.flush = 0;
        bus.out_ready = 0;
        drive(0, 0, 0, 0);
        bus.fwd_rs1 = 8;
        #1;
        check("fl_count", 64'(bus.count), 0);
        check("fl_valid", 64'(bus.out_valid), 0);
        check("fl_in_ready", 64'(bus.in_ready), 1);
        check("fl_hit1", 64'(bus.fwd_hit1), 0);
        check("fl_hit2", 64'(bus.fwd_hit2), 0);

        drive(1, 32'h61, 10, 1);
        tick();
        drive(1, 32'h62, 11, 1);
        tick();
        drive(0, 0, 0, 0);
        check("pre_rst_count", 64'(bus.count), 2);
        rst_n = 0;
        drive(1, 32'h63, 12, 1);
        tick();
        rst_n = 1;
        drive(0, 0, 0, 0);
        check("mid_rst_count", 64'(bus.count), 0);
        check("mid_rst_valid", 64'(bus.out_valid), 0);
        check("mid_rst_result", 64'(bus.out_result), 0);
        check("mid_rst_rd", 64'(bus.out_rd), 0);
        drive(1, 32'h77, 12, 1);
        tick();
        drive(0, 0, 0, 0);
        check("post_rst_valid", 64'(bus.out_valid), 1);
        check("post_rst_result", 64'(bus.out_result), 32'h77);
        check("post_rst_count", 64'(bus.count), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ex_result_buffer.md
EX_RESULT_BUFFER -- requirements
Module: ex_result_buffer

Interface
REQ-001 The module SHALL have parameter `size`, default 32, the result data width.
REQ-002 The module SHALL have parameter `depth`, default 2, the entry count; only value 2 is supported.
REQ-003 The module SHALL use a single clock; reset is synchronous and active-low.
REQ-004 Port `clk`  input  1  rising-edge clock.
REQ-005 Port `rst_n`  input  1  synchronous active-low reset.
REQ-006 Port `flush`  input  1  synchronous discard of all entries (branch mispredict/trap).
REQ-007 Port `in_valid`  input  1  execute stage presents a result.
REQ-008 Port `in_ready`  output  1  buffer can accept an entry this cycle.
REQ-009 Port `in_result`  input  size  ALU/logical unit result.
REQ-010 Port `in_rd`  input  5  destination register address.
REQ-011 Port `in_we`  input  1  destination register write enable.
REQ-012 Port `out_valid`  output  1  head entry available to the memory stage.
REQ-013 Port `out_ready`  input  1  memory stage accepts the head entry.
REQ-014 Port `out_result`  output  size  head entry result.
REQ-015 Port `out_rd`  output  5  head entry destination.
REQ-016 Port `out_we`  output  1  head entry write enable.
REQ-017 Ports `fwd_rs1`, `fwd_rs2`  input  5 each  decode source addresses to look up.
REQ-018 Ports `fwd_hit1`, `fwd_hit2`  output  1 each  matching buffered entry exists.
REQ-019 Ports `fwd_data1`, `fwd_data2`  output  size each  forwarded value.
REQ-020 Port `count`  output  2  occupied entries, 0..2.

Function
REQ-021 Push SHALL occur when in_valid && in_ready && !flush; the entry is written at the tail.
REQ-022 Pop SHALL occur when out_valid && out_ready && !flush; the head advances.
REQ-023 in_ready SHALL equal (count != 2); it SHALL NOT depend combinationally on out_ready.
REQ-024 When full, a pop SHALL free a slot visible as in_ready=1 in the next cycle only.
REQ-025 Push and pop in the same cycle at count=1 SHALL leave count=1 with the new entry at the tail.
REQ-026 Latency SHALL be one cycle: an entry pushed into an empty buffer is presented on out_* in the next cycle; there is no same-cycle input-to-output bypass.
REQ-027 out_valid SHALL equal (count != 0); out_result/out_rd/out_we SHALL be the head entry and SHALL be driven to 0 when out_valid=0.
REQ-028 While out_valid=1 and out_ready=0, out_* SHALL hold stable.
REQ-029 Head/tail pointers SHALL be 1 bit and wrap 1->0.
REQ-030 flush=1 SHALL set count to 0 and both pointers to 0 at the next edge; a same-cycle push or pop SHALL be ignored.
REQ-031 Forwarding SHALL be combinational: fwd_hitN=1 when any occupied entry has we=1 and rd==fwd_rsN and rd!=0.
REQ-032 When both entries match, fwd_dataN SHALL come from the younger (tail-side) entry.
REQ-033 fwd_rsN==0 SHALL never hit; on no hit fwd_dataN SHALL be 0.
REQ-034 Lookup SHALL reflect the current-cycle occupancy (before this edge's push/pop).

Reset
REQ-035 On a clock edge with rst_n=0: count=0, pointers=0, all entry storage=0; hence out_valid=0, out_*=0, fwd_hit*=0, in_ready=1 after the edge.
REQ-036 rst_n=0 SHALL override flush, push and pop; reset mid-operation discards all entries.

Verification
REQ-037 Push result=0xDEADBEEF rd=5 we=1 into empty, out_ready=0 -> next cycle out_valid=1, out_result=0xDEADBEEF, out_rd=5, count=1; held stable 3 cycles.
REQ-038 Push 0x11 then 0x22, out_ready=0 -> count=2, in_ready=0; third in_valid ignored; set out_ready=1 -> pops 0x11 then 0x22 in order, in_ready=1 one cycle after first pop.
REQ-039 count=1, simultaneous push 0x33 and pop -> count stays 1, next out_result=0x33.
REQ-040 Entries {rd=7,0xA}, {rd=7,0xB} (younger), fwd_rs1=7, fwd_rs2=0 -> fwd_hit1=1, fwd_data1=0xB, fwd_hit2=0, fwd_data2=0; entry rd=3 we=0 with fwd_rs1=3 -> no hit.
REQ-041 count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, no forwarding hits.
REQ-042 count=2, rst_n=0 for one edge -> count=0, out_*=0; push after release works normally.
